// File: rtl/modn_wrap_tracker_if.sv
// Bundle between a mod-N counter and its wrap tracker.
// The master drives the upstream count and clear, and the slave returns the
// cascade status.
interface modn_wrap_tracker_if #(
    parameter int WIDTH  = 4,
    parameter int HWIDTH = 3
);
    logic [WIDTH-1:0]  in_cnt;
    logic              clr;
    logic [HWIDTH-1:0] hi_cnt;
    logic              wrap_pulse;
    logic              locked;
    logic              ovf;
    logic              seq_err;

    modport master (
        output in_cnt, clr,
        input  hi_cnt, wrap_pulse, locked, ovf, seq_err
    );

    modport slave (
        input  in_cnt, clr,
        output hi_cnt, wrap_pulse, locked, ovf, seq_err
    );
endinterface

// File: rtl/modn_wrap_tracker.sv
// modn_wrap_tracker: checks that a mod-N count advances legally.
// A legal step is hold, +1, or N-1 -> 0. Each wrap is counted into a mod-M
// high digit. Sequence errors and overflow are reported as sticky flags.
// Optional feature macro MODN_WRAP_SAT_EN behaves as follows:
//   - Defined: hi_cnt saturates at M-1 and the tracker parks in HALT.
//   - Undefined: hi_cnt rolls over to 0 and tracking continues.
module modn_wrap_tracker #(
    parameter int N      = 10,
    parameter int WIDTH  = 4,
    parameter int M      = 6,
    parameter int HWIDTH = 3
) (
    input  logic clk,
    input  logic rstn,
    modn_wrap_tracker_if.slave bus
);
    localparam logic [WIDTH-1:0]  LAST  = WIDTH'(N - 1);
    localparam logic [HWIDTH-1:0] HLAST = HWIDTH'(M - 1);

    localparam logic [1:0] S_SYNC = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
`ifdef MODN_WRAP_SAT_EN
    localparam logic [1:0] S_HALT = 2'd2;
`endif

    logic [1:0]        state, state_nx;
    logic [WIDTH-1:0]  prev_q;
    logic [HWIDTH-1:0] hi_q, hi_nx;
    logic              ovf_q, ovf_nx;
    logic              err_q, err_nx;
    logic              pulse_q, pulse_nx;
    logic              locked_q;

    logic step_hold, step_inc, step_wrap, step_bad, in_range;

    // Classify the step from the previous sample to the current one.
    always_comb begin
        in_range  = (bus.in_cnt <= LAST);
        step_hold = (bus.in_cnt == prev_q);
        step_inc  = (prev_q < LAST) && (bus.in_cnt == prev_q + WIDTH'(1));
        step_wrap = (prev_q == LAST) && (bus.in_cnt == '0);
        step_bad  = !in_range || !(step_hold || step_inc || step_wrap);
    end

    // Next-state logic. clr overrides whatever the step would have done.
    always_comb begin
        state_nx = state;
        hi_nx    = hi_q;
        ovf_nx   = ovf_q;
        err_nx   = err_q;
        pulse_nx = 1'b0;
        case (state)
            S_SYNC: begin
                // The first zero only establishes alignment. It is never a wrap.
                if (bus.in_cnt == '0)
                    state_nx = S_RUN;
            end
            S_RUN: begin
                if (step_wrap) begin
                    pulse_nx = 1'b1;
                    if (hi_q == HLAST) begin
                        ovf_nx = 1'b1;
`ifdef MODN_WRAP_SAT_EN
                        state_nx = S_HALT;
`else
                        hi_nx = '0;
`endif
                    end else begin
                        hi_nx = hi_q + HWIDTH'(1);
                    end
                end else if (step_bad) begin
                    err_nx   = 1'b1;
                    state_nx = S_SYNC;
                end
            end
`ifdef MODN_WRAP_SAT_EN
            S_HALT: begin
                // Parked after saturation. Only clr or reset leave this state.
                state_nx = S_HALT;
            end
`endif
            default: state_nx = S_SYNC;
        endcase
        if (bus.clr) begin
            state_nx = S_SYNC;
            hi_nx    = '0;
            ovf_nx   = 1'b0;
            err_nx   = 1'b0;
            pulse_nx = 1'b0;
        end
    end

    // Register state and outputs. prev_q samples the input every cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_SYNC;
            prev_q   <= '0;
            hi_q     <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            pulse_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state    <= state_nx;
            prev_q   <= bus.in_cnt;
            hi_q     <= hi_nx;
            ovf_q    <= ovf_nx;
            err_q    <= err_nx;
            pulse_q  <= pulse_nx;
            locked_q <= (state_nx == S_RUN);
        end
    end

    assign bus.hi_cnt     = hi_q;
    assign bus.wrap_pulse = pulse_q;
    assign bus.locked     = locked_q;
    assign bus.ovf        = ovf_q;
    assign bus.seq_err    = err_q;
endmodule

// File: tb/tb_modn_wrap_tracker.sv
// Directed bench for modn_wrap_tracker.
// A behavioural model predicts every output, and a single compare process
// checks the DUT against it on each falling edge. The directed sequence adds
// hand-computed literal checks.
module tb_modn_wrap_tracker;
    localparam int N = 10, WIDTH = 4, M = 6, HWIDTH = 3;

    logic clk = 1'b0;
    logic rstn;
    int   errors = 0;
    int   checks = 0;

    modn_wrap_tracker_if #(.WIDTH(WIDTH), .HWIDTH(HWIDTH)) bus ();

    modn_wrap_tracker #(.N(N), .WIDTH(WIDTH), .M(M), .HWIDTH(HWIDTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model, expressed in terms of the count rules.
    bit m_valid = 0;
    int m_prev, m_hi;
    bit m_run, m_halt, m_ovf, m_err, m_pulse;

    always @(posedge clk) begin
        int  v;
        bit  wrap, legal;
        v = int'(bus.in_cnt);
        if (!rstn) begin
            m_valid = 1; m_hi = 0; m_run = 0; m_halt = 0;
            m_ovf = 0; m_err = 0; m_pulse = 0; m_prev = 0;
        end else begin
            m_pulse = 0;
            wrap  = (m_prev == N - 1) && (v == 0);
            legal = (v < N) && (v == m_prev || v == (m_prev + 1) % N);
            if (bus.clr) begin
                m_hi = 0; m_ovf = 0; m_err = 0; m_run = 0; m_halt = 0;
            end else if (m_halt) begin
                // parked
            end else if (!m_run) begin
                m_run = (v == 0);
            end else if (wrap) begin
                m_pulse = 1;
                if (m_hi == M - 1) m_ovf = 1;
`ifdef MODN_WRAP_SAT_EN
                if (m_hi == M - 1) begin m_halt = 1; m_run = 0; end
                else m_hi = m_hi + 1;
`else
                m_hi = (m_hi + 1) % M;
`endif
            end else if (!legal) begin
                m_err = 1; m_run = 0;
            end
            m_prev = v;
        end
    end

    // Compare process: outputs are registered, so sample them mid-cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cmp_hi_cnt", int'(bus.hi_cnt), m_hi);
            check("cmp_wrap_pulse", int'(bus.wrap_pulse), int'(m_pulse));
            check("cmp_locked", int'(bus.locked), int'(m_run));
            check("cmp_ovf", int'(bus.ovf), int'(m_ovf));
            check("cmp_seq_err", int'(bus.seq_err), int'(m_err));
        end
    end

    int cyc = 0, npulse = 0, p0 = -1, p1 = -1;

    // Apply one cycle of stimulus, then return at the following falling edge.
    task automatic step(input int v, input bit c = 1'b0, input bit r = 1'b1);
        bus.in_cnt = WIDTH'(v);
        bus.clr    = c;
        rstn       = r;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (bus.wrap_pulse) begin
            npulse++;
            if (p0 < 0) p0 = cyc; else if (p1 < 0) p1 = cyc;
        end
    endtask

    initial begin
        bus.in_cnt = '0;
        bus.clr    = 1'b0;
        rstn       = 1'b0;

        // Reset
        step(0, 0, 0);
        step(0, 0, 0);
        check("rst_hi_cnt", int'(bus.hi_cnt), 0);
        check("rst_locked", int'(bus.locked), 0);
        check("rst_pulse", int'(bus.wrap_pulse), 0);
        check("rst_ovf", int'(bus.ovf), 0);
        check("rst_seq_err", int'(bus.seq_err), 0);
        step(0);
        check("lock_after_rst", int'(bus.locked), 1);
        check("lock_no_pulse", int'(bus.wrap_pulse), 0);

        // Normal cascade: 25 cycles
        npulse = 0; p0 = -1; p1 = -1;
        for (int k = 1; k <= 25; k++) step(k % N);
        check("casc_pulses", npulse, 2);
        check("casc_spacing", p1 - p0, 10);
        check("casc_hi_cnt", int'(bus.hi_cnt), 2);
        check("casc_seq_err", int'(bus.seq_err), 0);

        // Sequence error: walk to 3, then jump to 7
        for (int k = 6; k <= 13; k++) step(k % N);
        check("pre_err_hi", int'(bus.hi_cnt), 3);
        step(7);
        check("seq_err_set", int'(bus.seq_err), 1);
        check("seq_err_unlock", int'(bus.locked), 0);
        step(0);
        check("relock", int'(bus.locked), 1);
        check("err_sticky", int'(bus.seq_err), 1);

        // clr clears the sticky flags and forces resync
        step(3, 1);
        check("clr_err", int'(bus.seq_err), 0);
        check("clr_hi", int'(bus.hi_cnt), 0);
        check("clr_unlock", int'(bus.locked), 0);
        step(0);

        // Out-of-range input value
        step(12);
        check("oor_err", int'(bus.seq_err), 1);
        check("oor_unlock", int'(bus.locked), 0);
        step(0);
        step(0, 1);
        step(0);
        check("oor_relock", int'(bus.locked), 1);

        // Overflow: six wraps, then one more decade
        for (int k = 1; k <= 60; k++) step(k % N);
        check("ovf_flag", int'(bus.ovf), 1);
        check("ovf_pulse", int'(bus.wrap_pulse), 1);
`ifdef MODN_WRAP_SAT_EN
        check("ovf_hi_sat", int'(bus.hi_cnt), 5);
        check("ovf_halt", int'(bus.locked), 0);
`else
        check("ovf_hi_roll", int'(bus.hi_cnt), 0);
        check("ovf_locked", int'(bus.locked), 1);
`endif
        npulse = 0; p0 = -1; p1 = -1;
        for (int k = 61; k <= 70; k++) step(k % N);
`ifdef MODN_WRAP_SAT_EN
        check("halt_no_pulse", npulse, 0);
        check("halt_hi", int'(bus.hi_cnt), 5);
`else
        check("roll_pulse", npulse, 1);
        check("roll_hi", int'(bus.hi_cnt), 1);
`endif

        // clr on the wrap cycle
        step(0, 1);
        step(0);
        for (int k = 1; k <= 9; k++) step(k);
        step(0, 1);
        check("clrwrap_pulse", int'(bus.wrap_pulse), 0);
        check("clrwrap_hi", int'(bus.hi_cnt), 0);
        check("clrwrap_ovf", int'(bus.ovf), 0);
        step(0);

        // Reset in the middle of a run at hi_cnt = 3
        for (int k = 1; k <= 30; k++) step(k % N);
        check("mid_hi3", int'(bus.hi_cnt), 3);
        step(1, 0, 0);
        check("mid_rst_hi", int'(bus.hi_cnt), 0);
        check("mid_rst_locked", int'(bus.locked), 0);
        check("mid_rst_pulse", int'(bus.wrap_pulse), 0);
        step(1);
        check("mid_no_lock_nonzero", int'(bus.locked), 0);
        step(0);
        check("mid_relock", int'(bus.locked), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
